aes_round_tail: RTL and testbench

- Downstream neighbour of the 128-bit SubBytes stage in the AES-128/256 round datapath.
- Consumes the post-SubBytes state and applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
- Two-stage pipeline with valid/ready handshakes on both sides; its output feeds the round register or the ciphertext output.

---
 rtl/aes_round_tail.sv | 131 +++++++++++++
 tb/tb_aes_round_tail.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_tail.sv
// aes_round_tail: ShiftRows -> MixColumns (bypassed on the final round) ->
// AddRoundKey, as a two-stage valid/ready pipeline sitting behind SubBytes.
// Byte 0 of the state is [127:120]; bytes are column-major (4 bytes per column).
module aes_round_tail #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [127:0]     in_key,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127-8*(rw+4*c) -: 8] = s[127-8*(rw+4*((c+rw)%4)) -: 8];
      end
    end
    return r;
  endfunction

  // One column times the circulant {02,03,01,01}; 03*x is folded as xtime(x)^x.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return r;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [127:0]     s1_sel_q,   s1_sel_d;
  logic [127:0]     s1_key_q,   s1_key_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [127:0]     s2_state_q, s2_state_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

  logic             s1_adv, s2_adv;
  logic [127:0]     sr_w, mc_w;

  assign sr_w = shift_rows(in_state);
  assign mc_w = mix_columns(sr_w);

  // Ready chain and next-state for both stages; a stage advances when it is
  // empty or its contents are leaving this cycle.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_ready   = s1_adv;

    s1_valid_d = s1_valid_q;
    s1_sel_d   = s1_sel_q;
    s1_key_d   = s1_key_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_state_d = s2_state_q;
    s2_tag_d   = s2_tag_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sel_d = in_last ? sr_w : mc_w;
        s1_key_d = in_key;
        s1_tag_d = in_tag;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_state_d = s1_sel_q ^ s1_key_q;
        s2_tag_d   = s1_tag_q;
      end
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= '0;
      s1_key_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_state_q <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sel_q   <= s1_sel_d;
      s1_key_q   <= s1_key_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_state_q <= s2_state_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_state = s2_state_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_aes_round_tail.sv
// Bench for aes_round_tail: known-answer table, streaming, backpressure,
// random handshakes and mid-flight reset, all checked through a scoreboard.
module tb_aes_round_tail;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_state;
  logic [127:0]     in_key;
  logic             in_last;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_state;
  logic [TAG_W-1:0] out_tag;

  aes_round_tail #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_key(in_key), .in_last(in_last), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0]     state;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  typedef struct {
    logic [127:0]     state;
    logic [127:0]     key;
    logic             last;
    logic [TAG_W-1:0] tag;
    logic [127:0]     expected;
  } vec_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc_cnt = 0;
  int               acc_cnt = 0;
  bit               lat_check = 0;
  bit               tag_mono = 0;
  bit               exp_en = 0;
  logic [127:0]     exp_val;
  logic [TAG_W-1:0] last_tag;
  bit               stall_prev = 0;
  logic [127:0]     stall_state;
  logic [TAG_W-1:0] stall_tag;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a[16];
    logic [7:0]   b[16];
    logic [7:0]   m[16];
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        b[rw+4*c] = a[rw+4*((c+rw)%4)];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        m[rw+4*c] = gmul(8'h02, b[rw+4*c]) ^ gmul(8'h03, b[(rw+1)%4+4*c])
                  ^ b[(rw+2)%4+4*c] ^ b[(rw+3)%4+4*c];
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = (last ? b[i] : m[i]) ^ k[127-8*i -: 8];
    return r;
  endfunction

  // One clock: sample at the falling edge, score what will transfer on the
  // next rising edge, then return just after that edge for new stimulus.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc_cnt++;
    chk1("in_ready", in_ready, (sb.size() < 2) || out_ready);
    if (stall_prev) begin
      chk1("stall_valid", out_valid, 1'b1);
      chk("stall_state", out_state, stall_state);
      chk(" stall_tag", 128'(out_tag), 128'(stall_tag));
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got beat %h tag %0d required none", out_state, out_tag);
      end else begin
        e = sb.pop_front();
        chk("out_state", out_state, e.state);
        chk("out_tag", 128'(out_tag), 128'(e.tag));
        if (lat_check) chk("latency", 128'(cyc_cnt - e.cyc), 128'(2));
        if (tag_mono) begin
          chk("tag_order", 128'(out_tag), 128'(TAG_W'(last_tag + 1'b1)));
          last_tag = out_tag;
        end
      end
    end
    stall_prev  = out_valid && !out_ready;
    stall_state = out_state;
    stall_tag   = out_tag;
    if (in_valid && in_ready) begin
      e.state = exp_en ? exp_val : ref_round(in_state, in_key, in_last);
      e.tag   = in_tag;
      e.cyc   = cyc_cnt;
      sb.push_back(e);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats left required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic rand_beat(input logic [TAG_W-1:0] tag);
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
    in_last  = 1'($urandom_range(0, 1));
    in_tag   = tag;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[2];
    int   target;
    int   budget;

    vecs[0] = '{state: 128'hd42711aee0bf98f1b8b45de51e415230,
                key:   128'ha0fafe1788542cb123a339392a6c7605,
                last:  1'b0, tag: 4'd1,
                expected: 128'ha49c7ff2689f352b6b5bea43026a5049};
    vecs[1] = '{state: 128'he9098972cb31075f3d327d94af2e2cb5,
                key:   128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                last:  1'b1, tag: 4'd9,
                expected: 128'h3925841d02dc09fbdc118597196a0b32};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_key    = '0;
    in_last   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_state", out_state, 128'h0);
    chk("rst_out_tag", 128'(out_tag), 128'h0);
    chk1("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Known-answer table, single beats with exact latency
    lat_check = 1;
    for (int i = 0; i < 2; i++) begin
      exp_en   = 1;
      exp_val  = vecs[i].expected;
      in_valid = 1'b1;
      in_state = vecs[i].state;
      in_key   = vecs[i].key;
      in_last  = vecs[i].last;
      in_tag   = vecs[i].tag;
      cycle();
      exp_en   = 0;
      drain(10);
    end

    // Streaming: 16 back-to-back beats
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      rand_beat(TAG_W'(i));
      cycle();
    end
    drain(10);
    lat_check = 0;

    // Backpressure mid-stream
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      rand_beat(TAG_W'(i));
      cycle();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_beat(TAG_W'(4 + i));
      cycle();
    end
    chk("bp_buffered", 128'(sb.size()), 128'(2));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_beat(TAG_W'(9 + i));
      cycle();
    end
    drain(10);

    // Random in_valid / out_ready for 1000 beats, consecutive tags
    tag_mono = 1;
    last_tag = TAG_W'(acc_cnt - 1);
    target   = acc_cnt + 1000;
    budget   = 0;
    while (acc_cnt < target && budget < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      rand_beat(TAG_W'(acc_cnt));
      cycle();
      budget++;
    end
    if (acc_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL random_accept_timeout: got %0d beats required %0d", acc_cnt, target);
    end
    drain(20);
    tag_mono = 0;

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_beat(4'd3);
    cycle();
    rand_beat(4'd4);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("inflight_before_rst", 128'(sb.size()), 128'(2));
    rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_state", out_state, 128'h0);
    chk("midrst_out_tag", 128'(out_tag), 128'h0);
    sb.delete();
    stall_prev = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk1("post_rst_no_stale", out_valid, 1'b0);
    end
    lat_check = 1;
    in_valid  = 1'b1;
    rand_beat(4'd7);
    cycle();
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
